// File: rtl/uart_rx_indicator.sv
// uart_rx_indicator: status-LED driver for a UART receiver.
//
// Watches the receiver's bit clock and bit counter, which both live in the rx_clk
// domain, from the int_clk domain. Each falling edge of the synchronized rx_clk is a
// sample strobe. On each strobe the bit index is checked against the expected
// 1..9,0 sequence. A green flash marks each good frame and a red flash marks a
// sequence error or a stall. Flashes are stretched so that they stay visible.
//
// Ports:
//   int_clk    in   system clock; all state updates on its rising edge
//   rst_n      in   asynchronous active-low reset
//   bit_ID     in   [3:0] receiver bit index (0 = idle/stop, 1..9 = frame bits)
//   rx_clk     in   receiver bit clock, low while idle
//   green_LED  out  frame in progress, or hold after a good frame
//   red_LED    out  hold after a sequence error or a stall
module uart_rx_indicator #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 5_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       int_clk,
    input  logic       rst_n,
    input  logic [3:0] bit_ID,
    input  logic       rx_clk,
    output logic       green_LED,
    output logic       red_LED
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Synchronizers
    logic [SYNC_STAGES-1:0] rx_sync_q;
    logic [3:0]             id_sync_q [SYNC_STAGES];
    logic                   rx_prev_q;

    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q <= '0;
            rx_prev_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                id_sync_q[i] <= 4'd0;
            end
        end else begin
            rx_sync_q    <= {rx_sync_q[SYNC_STAGES-2:0], rx_clk};
            rx_prev_q    <= rx_sync_q[SYNC_STAGES-1];
            id_sync_q[0] <= bit_ID;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                id_sync_q[i] <= id_sync_q[i-1];
            end
        end
    end

    logic       strobe;
    logic [3:0] cur_id;

    // bit_ID is stable for the whole high phase of rx_clk. Its synchronized copy
    // is therefore valid when the falling edge of rx_clk comes out of the chain.
    assign strobe = rx_prev_q & ~rx_sync_q[SYNC_STAGES-1];
    assign cur_id = id_sync_q[SYNC_STAGES-1];

    // Tracking state
    logic [3:0]    prev_id_q, prev_id_d;
    logic          active_q, active_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [HW-1:0] green_hold_q, green_hold_d;
    logic [HW-1:0] red_hold_q, red_hold_d;
    logic [3:0]    expected;

    always_comb begin
        prev_id_d    = prev_id_q;
        active_d     = active_q;
        wd_d         = wd_q;
        green_hold_d = (green_hold_q != '0) ? green_hold_q - HW'(1) : '0;
        red_hold_d   = (red_hold_q != '0) ? red_hold_q - HW'(1) : '0;
        expected     = (prev_id_q == 4'd9) ? 4'd0 : prev_id_q + 4'd1;

        if (strobe) begin
            // A strobe always clears the watchdog, even when a timeout falls in the
            // same cycle.
            wd_d = '0;
            if (cur_id == expected && cur_id <= 4'd9) begin
                prev_id_d = cur_id;
                if (cur_id == 4'd0) begin
                    active_d     = 1'b0;
                    green_hold_d = HOLD_LOAD;
                end else begin
                    active_d = 1'b1;
                end
            end else begin
                red_hold_d = HOLD_LOAD;
                // Resync to the observed index so that one glitch flags only once.
                prev_id_d  = (cur_id <= 4'd9) ? cur_id : 4'd0;
                active_d   = (prev_id_d != 4'd0);
            end
        end else if (!active_q) begin
            wd_d = '0;
        end else if (wd_q == TIMEOUT_LAST) begin
            red_hold_d = HOLD_LOAD;
            active_d   = 1'b0;
            prev_id_d  = 4'd0;
            wd_d       = '0;
        end else begin
            wd_d = wd_q + TW'(1);
        end
    end

    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_id_q    <= 4'd0;
            active_q     <= 1'b0;
            wd_q         <= '0;
            green_hold_q <= '0;
            red_hold_q   <= '0;
            green_LED    <= 1'b0;
            red_LED      <= 1'b0;
        end else begin
            prev_id_q    <= prev_id_d;
            active_q     <= active_d;
            wd_q         <= wd_d;
            green_hold_q <= green_hold_d;
            red_hold_q   <= red_hold_d;
            // The LEDs are driven from next-state values, so they change one
            // cycle after the strobe.
            green_LED    <= active_d | (green_hold_d != '0);
            red_LED      <= (red_hold_d != '0);
        end
    end

endmodule

// File: tb/tb_uart_rx_indicator.sv
// Bench for uart_rx_indicator. The stimulus queues each expected LED change
// ({green, red} plus the cycle it should appear on). The monitor pops one entry on
// every observed LED change and compares the value and the timing (+/-1 cycle).
module tb_uart_rx_indicator;

    localparam int SYNC = 2;
    localparam int HOLD = 20;
    localparam int TO   = 60;
    localparam int LAT  = SYNC + 1;  // rx_clk fall to LED change

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bit_ID = 4'd0;
    logic       rx_clk = 1'b0;
    logic       green_LED, red_LED;

    uart_rx_indicator #(
        .SYNC_STAGES   (SYNC),
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .int_clk  (clk),
        .rst_n    (rst_n),
        .bit_ID   (bit_ID),
        .rx_clk   (rx_clk),
        .green_LED(green_LED),
        .red_LED  (red_LED)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic g;
        logic r;
        int   at;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [1:0] last_led = 2'b00;

    task automatic expect_led(input logic g, input logic r, input int at);
        exp_t e;
        e.g = g;
        e.r = r;
        e.at = at;
        q.push_back(e);
    endtask

    // Monitor: any LED change consumes one expectation.
    always @(negedge clk) begin
        if ({green_LED, red_LED} !== last_led) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_led_change got g=%0b r=%0b at cyc %0d, required no change",
                         green_LED, red_LED, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (green_LED !== e.g || red_LED !== e.r || cyc < e.at - 1 || cyc > e.at + 1) begin
                    errors++;
                    $display("FAIL led_event got g=%0b r=%0b at cyc %0d, required g=%0b r=%0b at cyc %0d",
                             green_LED, red_LED, cyc, e.g, e.r, e.at);
                end
            end
            last_led = {green_LED, red_LED};
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Low gap, then a 4-cycle high phase carrying id. Returns the cycle of the fall.
    task automatic send(input logic [3:0] id, input int gap, output int t);
        repeat (gap) @(negedge clk);
        bit_ID = id;
        rx_clk = 1'b1;
        repeat (4) @(negedge clk);
        rx_clk = 1'b0;
        t = cyc;
    endtask

    initial begin
        int t, t0, ts;

        // Reset state
        idle(3);
        checks++;
        if (green_LED !== 1'b0 || red_LED !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got g=%0b r=%0b, required g=0 r=0", green_LED, red_LED);
        end
        rst_n = 1'b1;
        idle(5);

        // Normal frame 1..9,0
        for (int i = 1; i <= 9; i++) begin
            send(4'(i), 4, t);
            if (i == 1) expect_led(1'b1, 1'b0, t + LAT);
        end
        send(4'd0, 4, t);
        expect_led(1'b0, 1'b0, t + LAT + HOLD);
        idle(30);

        // Skipped bit 1,2,4 then 5..9,0
        send(4'd1, 4, t);
        expect_led(1'b1, 1'b0, t + LAT);
        send(4'd2, 4, t);
        send(4'd4, 4, t);
        expect_led(1'b1, 1'b1, t + LAT);
        expect_led(1'b1, 1'b0, t + LAT + HOLD);
        for (int i = 5; i <= 9; i++) send(4'(i), 4, t);
        send(4'd0, 4, t);
        expect_led(1'b0, 1'b0, t + LAT + HOLD);
        idle(30);

        // Illegal value 12, then 1 is accepted and the frame completes
        send(4'd12, 4, ts);
        expect_led(1'b0, 1'b1, ts + LAT);
        send(4'd1, 4, t);
        expect_led(1'b1, 1'b1, t + LAT);
        expect_led(1'b1, 1'b0, ts + LAT + HOLD);
        for (int i = 2; i <= 9; i++) send(4'(i), 4, t);
        send(4'd0, 4, t);
        expect_led(1'b0, 1'b0, t + LAT + HOLD);
        idle(30);

        // Stall: 1..4 then rx_clk held high
        send(4'd1, 4, t);
        expect_led(1'b1, 1'b0, t + LAT);
        for (int i = 2; i <= 4; i++) send(4'(i), 4, t);
        expect_led(1'b0, 1'b1, t + LAT + TO);
        expect_led(1'b0, 1'b0, t + LAT + TO + HOLD);
        idle(4);
        bit_ID = 4'd5;
        rx_clk = 1'b1;
        idle(100);
        // Drop rx_clk under reset so that the fall produces no strobe
        rst_n  = 1'b0;
        rx_clk = 1'b0;
        bit_ID = 4'd0;
        idle(3);
        rst_n = 1'b1;
        idle(5);

        // Reset mid-frame after bit 5, then 6 is out of sequence
        send(4'd1, 4, t);
        expect_led(1'b1, 1'b0, t + LAT);
        for (int i = 2; i <= 5; i++) send(4'(i), 4, t);
        idle(4);
        @(negedge clk);
        expect_led(1'b0, 1'b0, cyc + 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (green_LED !== 1'b0 || red_LED !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got g=%0b r=%0b, required g=0 r=0", green_LED, red_LED);
        end
        idle(3);
        rst_n = 1'b1;
        idle(5);
        send(4'd6, 4, t);
        // prev_id resyncs to 6, so the frame counts as active and later stalls
        expect_led(1'b1, 1'b1, t + LAT);
        expect_led(1'b1, 1'b0, t + LAT + HOLD);
        expect_led(1'b0, 1'b1, t + LAT + TO);
        expect_led(1'b0, 1'b0, t + LAT + TO + HOLD);
        idle(100);

        // Retrigger: a second error at about half of HOLD restarts the full hold
        send(4'd12, 4, t0);
        expect_led(1'b0, 1'b1, t0 + LAT);
        send(4'd12, HOLD / 2 - 4, t);
        expect_led(1'b0, 1'b0, t + LAT + HOLD);
        idle(40);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d outstanding, required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
